// File: rtl/sample_iterator.sv
// Raster-walks a triangle's snapped bounding box at the current subsample step,
// emitting SAMPS x-adjacent sample positions per cycle to the sample test stage.
module sample_iterator #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int SAMPS  = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
  input  logic        [COLORS-1:0][SIGFIG-1:0]          color_R14U,
  input  logic signed [1:0][1:0][SIGFIG-1:0]            box_R14S,
  input  logic                                          validTri_R14H,
  input  logic        [3:0]                             subSample_RnnnnU,
  output logic                                          halt_RnnnnH,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S,
  output logic        [COLORS-1:0][SIGFIG-1:0]          color_R16U,
  output logic signed [1:0][SAMPS-1:0][SIGFIG-1:0]      sample_R16S,
  output logic        [SAMPS-1:0]                       validSamp_R16H
);

  typedef enum logic {WAIT_STATE = 1'b0, TEST_STATE = 1'b1} state_t;

  state_t state_r, next_state_s;

  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_r;
  logic [COLORS-1:0][SIGFIG-1:0]          color_r;
  logic signed [SIGFIG-1:0] ll_x_r, ll_y_r, ur_x_r, ur_y_r, cur_x_r, cur_y_r;

  logic [4:0]               shamt_s;
  logic signed [SIGFIG-1:0] step_s, samps_step_s;
  logic signed [SIGFIG-1:0] in_ll_x_s, in_ll_y_s, in_ur_x_s, in_ur_y_s;
  logic signed [SIGFIG-1:0] samp_x_s [SAMPS];
  logic [SAMPS-1:0]         samp_ok_s;
  logic                     degen_s, x_more_s, y_more_s;
  logic                     accept_s, adv_x_s, adv_y_s;

  assign halt_RnnnnH = (state_r == TEST_STATE);

  assign in_ll_x_s = $signed(box_R14S[0][0]);
  assign in_ll_y_s = $signed(box_R14S[0][1]);
  assign in_ur_x_s = $signed(box_R14S[1][0]);
  assign in_ur_y_s = $signed(box_R14S[1][1]);

  // Step decode and per-lane sample positions; multiples of step are shifts.
  always_comb begin
    case (subSample_RnnnnU)
      4'b1000: shamt_s = 5'(RADIX);
      4'b0100: shamt_s = 5'(RADIX - 1);
      4'b0010: shamt_s = 5'(RADIX - 2);
      4'b0001: shamt_s = 5'(RADIX - 3);
      default: shamt_s = 5'(RADIX);
    endcase
    step_s       = {{(SIGFIG-1){1'b0}}, 1'b1} << shamt_s;
    samps_step_s = SIGFIG'(SAMPS) << shamt_s;
    for (int i = 0; i < SAMPS; i++) begin
      samp_x_s[i]  = cur_x_r + (SIGFIG'(i) << shamt_s);
      samp_ok_s[i] = (samp_x_s[i] <= ur_x_r);
    end
    degen_s  = (in_ll_x_s > in_ur_x_s) || (in_ll_y_s > in_ur_y_s);
    x_more_s = ((cur_x_r + samps_step_s) <= ur_x_r);
    y_more_s = ((cur_y_r + step_s) <= ur_y_r);
  end

  // Next-state and cursor-control decode.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    adv_x_s      = 1'b0;
    adv_y_s      = 1'b0;
    case (state_r)
      WAIT_STATE: begin
        if (validTri_R14H && !degen_s) begin
          accept_s     = 1'b1;
          next_state_s = TEST_STATE;
        end else begin
          next_state_s = WAIT_STATE;
        end
      end
      TEST_STATE: begin
        if (x_more_s) begin
          adv_x_s = 1'b1;
        end else if (y_more_s) begin
          adv_y_s = 1'b1;
        end else begin
          next_state_s = WAIT_STATE;
        end
      end
      default: next_state_s = WAIT_STATE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= WAIT_STATE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Triangle latch, cursor walk and registered batch outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      tri_r          <= '0;
      color_r        <= '0;
      ll_x_r         <= '0;
      ll_y_r         <= '0;
      ur_x_r         <= '0;
      ur_y_r         <= '0;
      cur_x_r        <= '0;
      cur_y_r        <= '0;
      tri_R16S       <= '0;
      color_R16U     <= '0;
      sample_R16S    <= '0;
      validSamp_R16H <= '0;
    end else begin
      if (accept_s) begin
        tri_r   <= tri_R14S;
        color_r <= color_R14U;
        ll_x_r  <= in_ll_x_s;
        ll_y_r  <= in_ll_y_s;
        ur_x_r  <= in_ur_x_s;
        ur_y_r  <= in_ur_y_s;
        cur_x_r <= in_ll_x_s;
        cur_y_r <= in_ll_y_s;
      end else if (adv_x_s) begin
        cur_x_r <= cur_x_r + samps_step_s;
      end else if (adv_y_s) begin
        cur_x_r <= ll_x_r;
        cur_y_r <= cur_y_r + step_s;
      end
      if (state_r == TEST_STATE) begin
        for (int i = 0; i < SAMPS; i++) begin
          sample_R16S[0][i] <= samp_x_s[i];
          sample_R16S[1][i] <= cur_y_r;
        end
        validSamp_R16H <= samp_ok_s;
        tri_R16S       <= tri_r;
        color_R16U     <= color_r;
      end else begin
        validSamp_R16H <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sample_iterator.sv
// Scoreboard bench for sample_iterator: directed boxes push hand-computed
// batches; a negedge monitor pops and compares each valid output batch.
module tb_sample_iterator;

  logic                          clk = 1'b0;
  logic                          rst;
  logic signed [2:0][2:0][23:0]  tri_i;
  logic        [2:0][23:0]       color_i;
  logic signed [1:0][1:0][23:0]  box_i;
  logic                          valid_tri;
  logic        [3:0]             sub_sample;
  logic                          halt;
  logic signed [2:0][2:0][23:0]  tri_o;
  logic        [2:0][23:0]       color_o;
  logic signed [1:0][3:0][23:0]  sample_o;
  logic        [3:0]             valid_samp;

  sample_iterator dut (
    .clk(clk), .rst(rst),
    .tri_R14S(tri_i), .color_R14U(color_i), .box_R14S(box_i),
    .validTri_R14H(valid_tri), .subSample_RnnnnU(sub_sample),
    .halt_RnnnnH(halt), .tri_R16S(tri_o), .color_R16U(color_o),
    .sample_R16S(sample_o), .validSamp_R16H(valid_samp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       v;
    logic [3:0][23:0] x;
    logic [23:0]      y;
    logic [23:0]      tag;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          gap = -1;
  int          prev_cyc = 0;
  logic [23:0] prev_tag = 24'd0;
  logic        have_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic void push(input logic [3:0] v, input int x0, input int x1,
                               input int x2, input int x3, input int y, input logic [23:0] tag);
    exp_t e;
    e.v   = v;
    e.x   = {24'(x3), 24'(x2), 24'(x1), 24'(x0)};
    e.y   = 24'(y);
    e.tag = tag;
    exp_q.push_back(e);
  endfunction

  // Monitor: every cycle with any valid sample must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if ((|valid_samp) === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_batch valid=%b x=%0h y=%0h", valid_samp, sample_o[0], sample_o[1]);
      end else begin
        e = exp_q.pop_front();
        check("batch_valid", 256'(valid_samp), 256'(e.v));
        check("batch_x", 256'(sample_o[0]), 256'(e.x));
        check("batch_y", 256'(sample_o[1]), 256'({4{e.y}}));
        check("batch_tri", 256'(tri_o), 256'({9{e.tag}}));
        check("batch_color", 256'(color_o), 256'({3{e.tag}}));
        if (have_prev && (e.tag != prev_tag)) gap = cyc - prev_cyc - 1;
        prev_tag  = e.tag;
        prev_cyc  = cyc;
        have_prev = 1'b1;
      end
    end
  end

  task automatic send(input int llx, input int lly, input int urx, input int ury,
                      input logic [3:0] ss, input logic [23:0] tag, output int n);
    logic ok;
    tri_i      = {9{tag}};
    color_i    = {3{tag}};
    box_i      = {24'(ury), 24'(urx), 24'(lly), 24'(llx)};
    sub_sample = ss;
    valid_tri  = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = !halt;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check("send_timeout", 256'(0), 256'(1));
    valid_tri = 1'b0;
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while ((exp_q.size() != 0 || halt) && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(nm, 256'(k < 200), 256'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int hc;
    rst        = 1'b1;
    valid_tri  = 1'b0;
    tri_i      = '0;
    color_i    = '0;
    box_i      = '0;
    sub_sample = 4'b1000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_halt", 256'(halt), 256'(0));
    check("rst_valid", 256'(valid_samp), 256'(0));
    check("rst_sample", 256'(sample_o), 256'(0));
    check("rst_tri", 256'(tri_o), 256'(0));
    check("rst_color", 256'(color_o), 256'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Unit box at step 1.0: two rows of two columns.
    push(4'b0011, 0, 1024, 2048, 3072, 0, 24'd1);
    push(4'b0011, 0, 1024, 2048, 3072, 1024, 24'd1);
    send(0, 0, 1024, 1024, 4'b1000, 24'd1, n);
    hc = 0;
    while (halt && hc < 50) begin
      @(posedge clk);
      #1;
      hc++;
    end
    check("unit_halt_cycles", 256'(hc), 256'(2));
    drain("unit_drain");

    // One row of eight columns at step 0.5.
    push(4'b1111, 0, 512, 1024, 1536, 0, 24'd2);
    push(4'b1111, 2048, 2560, 3072, 3584, 0, 24'd2);
    send(0, 0, 3584, 0, 4'b0100, 24'd2, n);
    drain("half_drain");

    // Back-to-back triangles at step 1.0.
    gap = -1;
    push(4'b0011, 0, 1024, 2048, 3072, 0, 24'd3);
    push(4'b0011, 0, 1024, 2048, 3072, 1024, 24'd3);
    send(0, 0, 1024, 1024, 4'b1000, 24'd3, n);
    push(4'b1111, 1024, 2048, 3072, 4096, 2048, 24'd4);
    send(1024, 2048, 4096, 2048, 4'b1000, 24'd4, n);
    drain("b2b_drain");
    check("b2b_bubble", 256'(gap), 256'(1));

    // Degenerate box is dropped; the next triangle goes straight in.
    send(2048, 0, 1024, 0, 4'b1000, 24'd5, n);
    check("degen_halt", 256'(halt), 256'(0));
    push(4'b0011, -256, -128, 0, 128, -256, 24'd6);
    send(-256, -256, -128, -256, 4'b0001, 24'd6, n);
    check("degen_next_accept", 256'(n), 256'(1));
    drain("eighth_drain");

    // Reset while the third batch of a six-batch triangle is being formed.
    push(4'b0011, 0, 1024, 2048, 3072, 0, 24'd7);
    push(4'b0011, 0, 1024, 2048, 3072, 1024, 24'd7);
    send(0, 0, 1024, 5120, 4'b1000, 24'd7, n);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_valid", 256'(valid_samp), 256'(0));
    check("midrst_halt", 256'(halt), 256'(0));
    check("midrst_sample", 256'(sample_o), 256'(0));
    check("midrst_tri", 256'(tri_o), 256'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("postrst_halt", 256'(halt), 256'(0));
    check("postrst_valid", 256'(valid_samp), 256'(0));
    push(4'b0001, 2048, 3072, 4096, 5120, 1024, 24'd8);
    send(2048, 1024, 2048, 1024, 4'b1000, 24'd8, n);
    drain("postrst_drain");

    check("queue_empty", 256'(exp_q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_iterator.md
Name: sample_iterator

Overview:
- Upstream neighbour of the sample test stage.
- Accepts one triangle per handshake together with its snapped bounding box.
- Walks the box in raster order at the current subsample step, emitting SAMPS x-adjacent sample locations per cycle, with triangle and color data alongside, into the sample test inputs.
- Stalls the upstream bounding-box stage via halt while a triangle is being iterated.

Parameters:
SIGFIG, 24, bits in color and position
RADIX, 10, fraction bits in position (1.0 = 1<<RADIX)
VERTS, 3, vertices per triangle
AXIS, 3, axes per vertex (x,y,z)
COLORS, 3, color channels
SAMPS, 4, samples emitted per cycle

Ports:
clk  in  1  clock; single clock domain
rst  in  1  reset, synchronous, active-high
tri_R14S  in  VERTS*AXIS*SIGFIG signed  triangle vertices
color_R14U  in  COLORS*SIGFIG  triangle color
box_R14S  in  2*2*SIGFIG signed  [0]=lower-left, [1]=upper-right; [*][0]=x, [*][1]=y; lower-left already snapped to step grid
validTri_R14H  in  1  triangle/box valid
subSample_RnnnnU  in  4  one-hot step: 1000=1.0, 0100=0.5, 0010=0.25, 0001=0.125 pixel; held static
halt_RnnnnH  out  1  upstream must hold inputs while high
tri_R16S  out  VERTS*AXIS*SIGFIG signed  latched triangle
color_R16U  out  COLORS*SIGFIG  latched color
sample_R16S  out  2*SAMPS*SIGFIG signed  [axis][samp] sample positions
validSamp_R16H  out  SAMPS  per-sample valid

Behaviour:
- step = 1<<(RADIX-k), where k = 0,1,2,3 for subSample = 1000,0100,0010,0001.
- FSM states:
  - WAIT_STATE (reset state):
    - halt = 0.
    - On validTri=1 with ll_x<=ur_x and ll_y<=ur_y: latch tri/color/box, cursor=(ll_x,ll_y), go to TEST_STATE.
    - On validTri=1 with a degenerate box (ll>ur on either axis): drop the triangle, stay in WAIT, emit nothing.
  - TEST_STATE:
    - halt = 1 (combinational from state).
    - Every cycle, register one batch from the current cursor:
      - sample[0][i] = cur_x + i*step
      - sample[1][i] = cur_y
      - validSamp[i] = (cur_x + i*step <= ur_x)
    - tri/color outputs = latched values.
- Cursor update each TEST cycle:
  - If cur_x + SAMPS*step <= ur_x: cur_x += SAMPS*step.
  - Else if cur_y + step <= ur_y: cur_x = ll_x, cur_y += step.
  - Else (last batch): go to WAIT_STATE.
- Latency:
  - Triangle accepted on the edge ending cycle t.
  - First batch is visible on outputs after the edge ending cycle t+1.
  - Last batch is visible one cycle after the FSM returns to WAIT; halt is already 0 in that cycle.
- Back-to-back triangles:
  - A triangle offered in the first WAIT cycle is accepted immediately.
  - There is exactly one bubble cycle (all validSamp=0) between triangles.
- Batch count per triangle = rows * ceil(cols/SAMPS), where:
  - cols = floor((ur_x-ll_x)/step)+1
  - rows = floor((ur_y-ll_y)/step)+1
- validTri while halt=1 is ignored; upstream holds its data, and no state is disturbed.
- Outputs registered; validSamp=0 on every cycle without a TEST batch.
- Data outputs hold their last value when invalid.
- Arithmetic: SIGFIG-bit signed adds; i*step and SAMPS*step formed by shifts. The box lies on screen, so no overflow handling is required.
- Reset (any cycle, including mid-triangle):
  - State goes to WAIT.
  - All outputs and latched registers are cleared to 0 at the next edge.
  - halt=0 from the cycle after reset is sampled.
  - No partial batch is emitted after reset.

Test Plan:
- Unit box ll=(0,0), ur=(1024,1024), step 1.0, SAMPS=4 -> 2 batches:
  - batch 1: y=0, x={0,1024,2048,3072}, valid=1100
  - batch 2: y=1024, same x, valid=1100
  - halt high for exactly 2 cycles.
- Box ll=(0,0), ur=(3584,0), step 0.5 (512) -> 8 columns, 2 batches:
  - batch 1: x=0..1536, valid=1111
  - batch 2: x=2048..3584, valid=1111
- Two triangles offered back-to-back -> second is accepted in the first WAIT cycle after the first's last batch; exactly one all-invalid cycle between the triangles' batches; tri/color outputs switch with the first batch of the second triangle.
- Degenerate box ll_x=2048 > ur_x=1024 -> no valid batch, halt never asserts, next triangle accepted next cycle.
- Reset asserted during the 3rd batch of a 6-batch triangle -> validSamp=0 and halt=0 from the next edge; FSM in WAIT; a new triangle afterwards iterates from its own ll.
- Step 0.125 (128), ll=(-256,-256), ur=(-128,-256) -> 1 batch: x={-256,-128,0,128}, valid=1100.
